// File: rtl/ball_pkg.sv
// Shared types and constants for the ball motion scheduler.
package ball_pkg;

  // Per-frame scheduler phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    BOUND  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // USB HID keycodes that steer the ball
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Default screen geometry (640x480 visible area)
  localparam int X_MIN_DEF    = 0;
  localparam int X_MAX_DEF    = 639;
  localparam int Y_MIN_DEF    = 0;
  localparam int Y_MAX_DEF    = 479;
  localparam int X_CENTER_DEF = 320;
  localparam int Y_CENTER_DEF = 240;
  localparam int STEP_DEF     = 1;
  localparam int SIZE_DEF     = 4;

  // Key decode result: whether the key steers, and the per-axis direction
  // as -1/0/+1 (multiplied by the step size in the datapath).
  typedef struct packed {
    logic       hit;
    logic [1:0] dx;  // 2'b01 = +, 2'b11 = -, 2'b00 = none
    logic [1:0] dy;
  } key_dir_t;

  function automatic key_dir_t decode_key(input logic [7:0] key);
    key_dir_t d;
    d = '{hit: 1'b0, dx: 2'b00, dy: 2'b00};
    case (key)
      KEY_W: d = '{hit: 1'b1, dx: 2'b00, dy: 2'b11};
      KEY_S: d = '{hit: 1'b1, dx: 2'b00, dy: 2'b01};
      KEY_A: d = '{hit: 1'b1, dx: 2'b11, dy: 2'b00};
      KEY_D: d = '{hit: 1'b1, dx: 2'b01, dy: 2'b00};
      default: d = '{hit: 1'b0, dx: 2'b00, dy: 2'b00};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Brings the asynchronous active-low vsync into the Clk domain and emits a
// registered one-cycle pulse on each synchronised 1->0 transition.
module vsync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vs,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_tick;
  logic w_fall;

  // Synchronised vs was high last cycle and is low now
  assign w_fall = r_prev & ~r_sync2;

  // Two-flop synchroniser, edge register and pulse register; reset to the
  // idle (high) level of vsync so release from reset never fakes an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_vs;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= w_fall;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Once-per-frame ball position scheduler: samples the keycode on a vsync
// falling edge, applies screen-edge bounces, then commits the new centre.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int X_MIN    = X_MIN_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MIN    = Y_MIN_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int X_CENTER = X_CENTER_DEF,
  parameter int Y_CENTER = Y_CENTER_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int SIZE     = SIZE_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic       frame_done,
  output logic       missed
);

  // 11-bit constants so bound checks never overflow a 10-bit coordinate
  localparam logic [10:0]        C_X_HI   = 11'(X_MAX);
  localparam logic [10:0]        C_Y_HI   = 11'(Y_MAX);
  localparam logic [10:0]        C_X_LO   = 11'(X_MIN + SIZE);
  localparam logic [10:0]        C_Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic [10:0]        C_SIZE   = 11'(SIZE);
  localparam logic signed [10:0] C_POS    = 11'(STEP);
  localparam logic signed [10:0] C_NEG    = -11'(STEP);
  localparam logic [9:0]         C_X_RST  = 10'(X_CENTER);
  localparam logic [9:0]         C_Y_RST  = 10'(Y_CENTER);

  state_t            r_state, w_state_nxt;
  logic signed [10:0] r_mx, r_my, w_mx_nxt, w_my_nxt;
  logic [9:0]        r_bx, r_by, w_bx_nxt, w_by_nxt;
  logic              r_fd, w_fd_nxt;
  logic              r_missed, w_missed_nxt;
  logic              w_tick;
  key_dir_t          w_key;
  logic [10:0]       w_bx_ext, w_by_ext;
  logic [10:0]       w_sum_x, w_sum_y;

  vsync_edge_detect u_vs_edge (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_vs   (vs),
    .o_tick (w_tick)
  );

  assign w_key    = decode_key(keycode);
  assign w_bx_ext = {1'b0, r_bx};
  assign w_by_ext = {1'b0, r_by};
  // Two's-complement add; the low 10 bits give the wrapped coordinate
  assign w_sum_x  = w_bx_ext + $unsigned(r_mx);
  assign w_sum_y  = w_by_ext + $unsigned(r_my);

  // State and datapath registers; reset wins over any in-flight frame
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_mx     <= '0;
      r_my     <= '0;
      r_bx     <= C_X_RST;
      r_by     <= C_Y_RST;
      r_fd     <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mx     <= w_mx_nxt;
      r_my     <= w_my_nxt;
      r_bx     <= w_bx_nxt;
      r_by     <= w_by_nxt;
      r_fd     <= w_fd_nxt;
      r_missed <= w_missed_nxt;
    end
  end

  // Next-state and per-phase motion/position updates
  always_comb begin
    w_state_nxt  = r_state;
    w_mx_nxt     = r_mx;
    w_my_nxt     = r_my;
    w_bx_nxt     = r_bx;
    w_by_nxt     = r_by;
    w_fd_nxt     = 1'b0;
    // A tick that lands mid-frame is dropped but remembered
    w_missed_nxt = r_missed | (w_tick & (r_state != IDLE));

    case (r_state)
      IDLE: begin
        if (w_tick) w_state_nxt = DECODE;
      end

      DECODE: begin
        // Unrecognised keys keep the previous heading
        if (w_key.hit) begin
          w_mx_nxt = (w_key.dx == 2'b01) ? C_POS :
                     (w_key.dx == 2'b11) ? C_NEG : 11'sd0;
          w_my_nxt = (w_key.dy == 2'b01) ? C_POS :
                     (w_key.dy == 2'b11) ? C_NEG : 11'sd0;
        end
        w_state_nxt = BOUND;
      end

      BOUND: begin
        // Edge bounces override the key heading, each axis on its own
        if (w_by_ext + C_SIZE >= C_Y_HI)  w_my_nxt = C_NEG;
        else if (w_by_ext <= C_Y_LO)      w_my_nxt = C_POS;
        if (w_bx_ext + C_SIZE >= C_X_HI)  w_mx_nxt = C_NEG;
        else if (w_bx_ext <= C_X_LO)      w_mx_nxt = C_POS;
        w_state_nxt = COMMIT;
      end

      COMMIT: begin
        w_bx_nxt    = w_sum_x[9:0];
        w_by_nxt    = w_sum_y[9:0];
        w_fd_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign BallX      = r_bx;
  assign BallY      = r_by;
  assign BallS      = 10'(SIZE);
  assign frame_done = r_fd;
  assign missed     = r_missed;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed scenarios plus random frames checked
// against a frame-level model of the motion rules.
module tb_ball_motion_ctrl;

  logic       Clk;
  logic       Reset;
  logic       vs;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, BallS;
  logic       frame_done, missed;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference state
  int m_bx, m_by, m_mx, m_my;

  ball_motion_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .vs         (vs),
    .keycode    (keycode),
    .BallX      (BallX),
    .BallY      (BallY),
    .BallS      (BallS),
    .frame_done (frame_done),
    .missed     (missed)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic void model_reset();
    m_bx = 320; m_by = 240; m_mx = 0; m_my = 0;
  endfunction

  // One whole frame: key steer, then bounce, then move
  function automatic void model_frame(input logic [7:0] key);
    case (key)
      8'h1A: begin m_mx = 0;  m_my = -1; end
      8'h16: begin m_mx = 0;  m_my = 1;  end
      8'h04: begin m_mx = -1; m_my = 0;  end
      8'h07: begin m_mx = 1;  m_my = 0;  end
      default: ;
    endcase
    if (m_by + 4 >= 479) m_my = -1; else if (m_by <= 4) m_my = 1;
    if (m_bx + 4 >= 639) m_mx = -1; else if (m_bx <= 4) m_mx = 1;
    m_bx = (m_bx + m_mx) & 1023;
    m_by = (m_by + m_my) & 1023;
  endfunction

  // Drop vs with a key held, wait for the commit, check position
  task automatic do_frame(input logic [7:0] key, input string tag, output int lat);
    bit seen;
    seen = 0; lat = 0;
    keycode = key;
    vs = 1'b0;
    model_frame(key);
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) begin lat = i; seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s frame_done: not seen within 20 cycles, required pulse", tag);
    end else begin
      checks++;
      if (BallX !== 10'(m_bx)) begin
        failures++;
        $display("FAIL %s BallX: got %0d required %0d", tag, BallX, m_bx);
      end
      checks++;
      if (BallY !== 10'(m_by)) begin
        failures++;
        $display("FAIL %s BallY: got %0d required %0d", tag, BallY, m_by);
      end
      @(negedge Clk);
      checks++;
      if (frame_done !== 1'b0) begin
        failures++;
        $display("FAIL %s frame_done width: got %b required 0 one cycle later", tag, frame_done);
      end
    end
    vs = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    checks++; if (BallX !== 10'd320) begin failures++; $display("FAIL reset BallX: got %0d required 320", BallX); end
    checks++; if (BallY !== 10'd240) begin failures++; $display("FAIL reset BallY: got %0d required 240", BallY); end
    checks++; if (BallS !== 10'd4)   begin failures++; $display("FAIL reset BallS: got %0d required 4", BallS); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done: got %b required 0", frame_done); end
    checks++; if (missed !== 1'b0) begin failures++; $display("FAIL reset missed: got %b required 0", missed); end
  endtask

  task automatic test_key_d();
    int lat;
    do_frame(8'h07, "key_d", lat);
    checks++;
    if (lat != 7) begin failures++; $display("FAIL key_d latency: got %0d required 7", lat); end
    checks++;
    if (BallX !== 10'd321) begin failures++; $display("FAIL key_d x: got %0d required 321", BallX); end
    for (int f = 0; f < 3; f++) do_frame(8'h00, "key_d_persist", lat);
    checks++;
    if (BallX !== 10'd324) begin failures++; $display("FAIL key_d persist x: got %0d required 324", BallX); end
  endtask

  task automatic test_bottom_bounce();
    int lat, guard;
    guard = 0;
    while (m_by != 475 && guard < 400) begin
      do_frame(8'h16, "down", lat);
      guard++;
    end
    do_frame(8'h16, "bottom_bounce", lat);
    checks++;
    if (BallY !== 10'd474) begin failures++; $display("FAIL bottom_bounce y: got %0d required 474", BallY); end
    do_frame(8'h00, "after_bottom", lat);
    do_frame(8'h00, "after_bottom", lat);
    checks++;
    if (BallY !== 10'd472) begin failures++; $display("FAIL after_bottom y: got %0d required 472", BallY); end
  endtask

  task automatic test_left_bounce();
    int lat, guard;
    logic [9:0] y_before;
    guard = 0;
    while (m_bx != 4 && guard < 700) begin
      do_frame(8'h04, "left", lat);
      guard++;
    end
    y_before = BallY;
    do_frame(8'h04, "left_bounce", lat);
    checks++;
    if (BallX !== 10'd5) begin failures++; $display("FAIL left_bounce x: got %0d required 5", BallX); end
    checks++;
    if (BallY !== y_before) begin failures++; $display("FAIL left_bounce y: got %0d required %0d", BallY, y_before); end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] keys [6];
    logic [7:0] k;
    keys[0] = 8'h1A; keys[1] = 8'h16; keys[2] = 8'h04;
    keys[3] = 8'h07; keys[4] = 8'h00; keys[5] = 8'h55;
    for (int f = 0; f < 40; f++) begin
      k = keys[$urandom_range(5)];
      if (k == 8'h55) k = 8'($urandom);
      // keycode noise outside DECODE must not matter
      keycode = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      do_frame(k, "random", lat);
    end
  endtask

  task automatic test_overrun();
    int pulses, lat;
    pulses = 0;
    keycode = 8'h1A;
    model_frame(8'h1A);
    vs = 1'b0; @(negedge Clk);
    vs = 1'b1; @(negedge Clk);
    vs = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL overrun commits: got %0d required 1", pulses); end
    checks++;
    if (missed !== 1'b1) begin failures++; $display("FAIL overrun missed: got %b required 1", missed); end
    checks++;
    if (BallY !== 10'(m_by)) begin failures++; $display("FAIL overrun y: got %0d required %0d", BallY, m_by); end
    vs = 1'b1;
    repeat (4) @(negedge Clk);
    do_frame(8'h00, "post_overrun", lat);
    checks++;
    if (missed !== 1'b1) begin failures++; $display("FAIL missed sticky: got %b required 1", missed); end
  endtask

  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    keycode = 8'h07;
    vs = 1'b0;
    repeat (5) @(negedge Clk);   // FSM now in BOUND
    Reset = 1'b1;
    @(negedge Clk);
    model_reset();
    checks++; if (BallX !== 10'd320) begin failures++; $display("FAIL mid_reset x: got %0d required 320", BallX); end
    checks++; if (BallY !== 10'd240) begin failures++; $display("FAIL mid_reset y: got %0d required 240", BallY); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL mid_reset frame_done: got %b required 0", frame_done); end
    checks++; if (missed !== 1'b0) begin failures++; $display("FAIL mid_reset missed: got %b required 0", missed); end
    Reset = 1'b0;
    vs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || BallX !== 10'd320) begin
      failures++;
      $display("FAIL mid_reset no_commit: pulses %0d x %0d required 0 and 320", pulses, BallX);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // Motion was cleared by reset: a no-key frame must not move the ball
    do_frame(8'h00, "idle_frame", lat);
    checks++;
    if (BallX !== 10'd320 || BallY !== 10'd240) begin
      failures++;
      $display("FAIL idle_frame pos: got %0d,%0d required 320,240", BallX, BallY);
    end
    do_frame(8'h1A, "b2b_w", lat);
    do_frame(8'h04, "b2b_a", lat);
    do_frame(8'h16, "b2b_s", lat);
  endtask

  initial begin
    Reset = 1'b1; vs = 1'b1; keycode = 8'h00;
    model_reset();
    test_reset();
    test_key_d();
    test_bottom_bounce();
    test_left_bounce();
    test_random();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
